feistel_core: RTL and testbench

FEISTEL_CORE -- requirements
Module: feistel_core

---
 rtl/feistel_core_pkg.sv | 42 ++++
 rtl/feistel_core_round_f.sv | 25 ++
 rtl/feistel_core.sv | 112 +++++++++++
 tb/tb_feistel_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feistel_core_pkg.sv
// Shared definitions for the 8-bit Feistel core.
// Holds the S-box tables, the expansion and permutation maps, and the FSM state encoding.
package feistel_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each table is flattened as {row, col}: row = {b3,b0}, col = {b2,b1}.
  localparam logic [1:0] S0_TAB [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };

  localparam logic [1:0] S1_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  // E_MAP[i] is the bit of the 4-bit half that drives expansion bit i.
  localparam logic [1:0] E_MAP [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};

  // P_MAP[i] is the bit of t = {S0,S1} that drives F output bit i.
  localparam logic [1:0] P_MAP [4] = '{2'd3, 2'd1, 2'd0, 2'd2};

  function automatic logic [1:0] sbox_lookup(input logic sel, input logic [3:0] nib);
    logic [3:0] idx;
    idx = {nib[3], nib[0], nib[2], nib[1]};
    if (sel) begin
      return S1_TAB[idx];
    end else begin
      return S0_TAB[idx];
    end
  endfunction

endpackage

// File: rtl/feistel_core_round_f.sv
// Combinational Feistel round function F(r, k): expand, key mix, two S-boxes, permute.
module feistel_round_f (
  input  logic [3:0] r,
  input  logic [7:0] k,
  output logic [3:0] f
);
  import feistel_core_pkg::*;

  logic [7:0] e_s;
  logic [7:0] v_s;
  logic [3:0] t_s;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_exp
    assign e_s[gi] = r[E_MAP[gi]];
  end

  assign v_s = e_s ^ k;
  assign t_s = {sbox_lookup(1'b0, v_s[7:4]), sbox_lookup(1'b1, v_s[3:0])};

  for (gi = 0; gi < 4; gi++) begin : g_perm
    assign f[gi] = t_s[P_MAP[gi]];
  end

endmodule

// File: rtl/feistel_core.sv
// Iterative 8-bit Feistel cipher: one round per clock, ready/valid on both sides.
// Keys and mode are latched on accept so the source may change them mid-operation.
module feistel_core #(
  parameter  int ROUNDS = 2,
  localparam int KEY_W  = 8 * ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_block,
  input  logic [KEY_W-1:0] in_keys,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_block
);
  import feistel_core_pkg::*;

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_t           state_r;
  logic [3:0]       l_r;
  logic [3:0]       r_r;
  logic [CW-1:0]    cnt_r;
  logic [KEY_W-1:0] keys_r;
  logic             dec_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [7:0]       out_block_r;

  logic [CW-1:0]    kidx_s;
  logic [7:0]       key_s;
  logic [3:0]       f_s;

  // Round key index: decryption walks the key schedule backwards.
  always_comb begin
    if (dec_r) begin
      kidx_s = LAST - cnt_r;
    end else begin
      kidx_s = cnt_r;
    end
  end

  assign key_s = keys_r[{kidx_s, 3'b000} +: 8];

  feistel_round_f u_round_f (
    .r (r_r),
    .k (key_s),
    .f (f_s)
  );

  // Control FSM, half registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      l_r         <= 4'h0;
      r_r         <= 4'h0;
      cnt_r       <= {CW{1'b0}};
      keys_r      <= {KEY_W{1'b0}};
      dec_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_block_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            l_r        <= in_block[7:4];
            r_r        <= in_block[3:0];
            keys_r     <= in_keys;
            dec_r      <= in_decrypt;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          l_r   <= r_r;
          r_r   <= l_r ^ f_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // Final swap undone: present {R_N, L_N}.
            out_block_r <= {l_r ^ f_s, r_r};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_block_r <= 8'h00;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_block_r <= 8'h00;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_block = out_block_r;

endmodule

// File: tb/tb_feistel_core.sv
// Self-checking bench for feistel_core: ROUNDS=1 and ROUNDS=2 instances against a reference model.
module tb_feistel_core;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_in_decrypt, a_out_valid, a_out_ready;
  logic [7:0]  a_in_block, a_in_keys, a_out_block;
  logic        b_in_valid, b_in_ready, b_in_decrypt, b_out_valid, b_out_ready;
  logic [7:0]  b_in_block, b_out_block;
  logic [15:0] b_in_keys;

  int checks;
  int errors;

  localparam logic [1:0] S0_REF [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd3, 2'd1, 2'd3, 2'd2}};
  localparam logic [1:0] S1_REF [4][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd2, 2'd0, 2'd1, 2'd3},
    '{2'd3, 2'd0, 2'd1, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd3}};

  feistel_core #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_block(a_in_block), .in_keys(a_in_keys), .in_decrypt(a_in_decrypt),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block));

  feistel_core #(.ROUNDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_block(b_in_block), .in_keys(b_in_keys), .in_decrypt(b_in_decrypt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_f(input logic [3:0] x, input logic [7:0] k);
    logic [7:0] e;
    logic [7:0] v;
    logic [3:0] t;
    e = {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]};
    v = e ^ k;
    t = {S0_REF[{v[7], v[4]}][{v[6], v[5]}], S1_REF[{v[3], v[0]}][{v[2], v[1]}]};
    return {t[2], t[0], t[1], t[3]};
  endfunction

  function automatic logic [7:0] model_cipher(input logic [7:0] blk, input logic [15:0] keys,
                                              input int rounds, input logic dec);
    logic [3:0] l, r, nr;
    int ki;
    l = blk[7:4];
    r = blk[3:0];
    for (int i = 0; i < rounds; i++) begin
      ki = dec ? (rounds - 1 - i) : i;
      nr = l ^ model_f(r, keys[8*ki +: 8]);
      l = r;
      r = nr;
    end
    return {r, l};
  endfunction

  // Drives one block through the selected instance; called at posedge+1 with the core idle.
  task automatic do_xact(input int which, input logic [7:0] blk, input logic [15:0] keys,
                         input logic dec, output logic [7:0] res, output int lat);
    if (which == 1) begin
      a_in_block = blk; a_in_keys = keys[7:0]; a_in_decrypt = dec; a_in_valid = 1'b1;
    end else begin
      b_in_block = blk; b_in_keys = keys; b_in_decrypt = dec; b_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    while (((which == 1) ? a_out_valid : b_out_valid) !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (which == 1) ? a_out_block : b_out_block;
    if (which == 1) a_out_ready = 1'b1; else b_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got=%b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got=%b exp=0", a_out_valid); end
    checks++; if (a_out_block !== 8'h00) begin errors++; $display("FAIL reset_out_block1 got=%h exp=00", a_out_block); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready2 got=%b exp=1", b_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got=%b exp=0", b_out_valid); end
    checks++; if (b_out_block !== 8'h00) begin errors++; $display("FAIL reset_out_block2 got=%h exp=00", b_out_block); end
  endtask

  task automatic test_single_round;
    logic [7:0] res, blk, key, exp;
    logic dec;
    int lat;
    checks++; if (model_f(4'b1000, 8'hA4) !== 4'b1101) begin errors++; $display("FAIL model_f_anchor got=%b exp=1101", model_f(4'b1000, 8'hA4)); end
    do_xact(1, 8'h68, 16'h00A4, 1'b0, res, lat);
    checks++; if (res !== 8'hB8) begin errors++; $display("FAIL r1_encrypt got=%h exp=b8", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL r1_enc_latency got=%0d exp=1", lat); end
    do_xact(1, 8'hB8, 16'h00A4, 1'b1, res, lat);
    checks++; if (res !== 8'h68) begin errors++; $display("FAIL r1_decrypt got=%h exp=68", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL r1_dec_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 20; i++) begin
      blk = 8'($urandom); key = 8'($urandom); dec = 1'($urandom);
      exp = model_cipher(blk, {8'h00, key}, 1, dec);
      do_xact(1, blk, {8'h00, key}, dec, res, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL r1_random blk=%h key=%h dec=%b got=%h exp=%h", blk, key, dec, res, exp); end
    end
  endtask

  task automatic test_roundtrip_all;
    logic [7:0] enc, dec_res;
    int lat;
    for (int i = 0; i < 256; i++) begin
      do_xact(2, 8'(i), 16'h3CA4, 1'b0, enc, lat);
      checks++; if (enc !== model_cipher(8'(i), 16'h3CA4, 2, 1'b0)) begin errors++; $display("FAIL r2_encrypt blk=%h got=%h exp=%h", i, enc, model_cipher(8'(i), 16'h3CA4, 2, 1'b0)); end
      checks++; if (lat != 2) begin errors++; $display("FAIL r2_enc_latency blk=%h got=%0d exp=2", i, lat); end
      do_xact(2, enc, 16'h3CA4, 1'b1, dec_res, lat);
      checks++; if (dec_res !== 8'(i)) begin errors++; $display("FAIL r2_roundtrip blk=%h got=%h exp=%h", i, dec_res, i); end
      checks++; if (lat != 2) begin errors++; $display("FAIL r2_dec_latency blk=%h got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_random_r2;
    logic [7:0] blk, res, exp;
    logic [15:0] keys;
    logic dec;
    int lat;
    for (int i = 0; i < 40; i++) begin
      blk = 8'($urandom); keys = 16'($urandom); dec = 1'($urandom);
      exp = model_cipher(blk, keys, 2, dec);
      do_xact(2, blk, keys, dec, res, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL r2_random blk=%h keys=%h dec=%b got=%h exp=%h", blk, keys, dec, res, exp); end
    end
  endtask

  task automatic test_stall;
    logic [7:0] blk, exp;
    logic [15:0] keys;
    blk = 8'($urandom); keys = 16'($urandom);
    exp = model_cipher(blk, keys, 2, 1'b0);
    b_in_block = blk; b_in_keys = keys; b_in_decrypt = 1'b0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_block = ~blk;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL stall_run_in_ready got=%b exp=0", b_in_ready); end
    repeat (2) begin @(posedge clk); #1; end
    for (int c = 0; c < 6; c++) begin
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", c, b_out_valid); end
      checks++; if (b_out_block !== exp) begin errors++; $display("FAIL stall_out_block cyc=%0d got=%h exp=%h", c, b_out_block, exp); end
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, b_in_ready); end
      if (c < 5) begin @(posedge clk); #1; end
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%b exp=0", b_out_valid); end
    checks++; if (b_out_block !== 8'h00) begin errors++; $display("FAIL stall_release_block got=%h exp=00", b_out_block); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got=%b exp=1", b_in_ready); end
  endtask

  task automatic test_key_change;
    logic [7:0] blk, exp;
    logic [15:0] keys;
    logic dec;
    int lat;
    for (int i = 0; i < 8; i++) begin
      blk = 8'($urandom); keys = 16'($urandom); dec = 1'($urandom);
      exp = model_cipher(blk, keys, 2, dec);
      b_in_block = blk; b_in_keys = keys; b_in_decrypt = dec; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_keys = ~keys;
      b_in_decrypt = ~dec;
      b_in_block = 8'($urandom);
      lat = 0;
      while (b_out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
        b_in_keys = 16'($urandom);
      end
      checks++; if (b_out_block !== exp) begin errors++; $display("FAIL keychg_result got=%h exp=%h", b_out_block, exp); end
      checks++; if (lat != 2) begin errors++; $display("FAIL keychg_latency got=%0d exp=2", lat); end
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op;
    b_in_block = 8'h5A; b_in_keys = 16'h1234; b_in_decrypt = 1'b0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_valid got=%b exp=0", b_out_valid); end
    checks++; if (b_out_block !== 8'h00) begin errors++; $display("FAIL rst_run_block got=%h exp=00", b_out_block); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL rst_done_precond got=%b exp=1", b_out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_valid got=%b exp=0", b_out_valid); end
    checks++; if (b_out_block !== 8'h00) begin errors++; $display("FAIL rst_done_block got=%h exp=00", b_out_block); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_in_ready got=%b exp=1", b_in_ready); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_result cyc=%0d got=%b exp=0", c, b_out_valid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_block = 8'h00; a_in_keys = 8'h00; a_in_decrypt = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_block = 8'h00; b_in_keys = 16'h0000; b_in_decrypt = 1'b0; b_out_ready = 1'b0;
    test_reset;
    test_single_round;
    test_roundtrip_all;
    test_random_r2;
    test_stall;
    test_key_change;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
